// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester data-memory arbiter:
// FSM encoding, requester IDs and default bus widths.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } arb_state_t;

    // With only two requesters, the winner ID is simply the aux bit of the one-hot vector.
    function automatic logic onehot_to_id(input logic [1:0] oh);
        return oh[REQ_AUX];
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Two-way winner selection. Ties go to CPU (fixed priority), or to the
// requester not granted last when MEM_ARB_RR_EN is defined.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[REQ_CPU] && req[REQ_AUX]) begin
`ifdef MEM_ARB_RR_EN
            if (last_gnt == REQ_CPU) begin
                gnt[REQ_AUX] = 1'b1;
            end else begin
                gnt[REQ_CPU] = 1'b1;
            end
`else
            gnt[REQ_CPU] = 1'b1;
`endif
        end else begin
            gnt = req;
        end
    end

`ifndef MEM_ARB_RR_EN
    // Fixed priority never looks at history; the port stays for a uniform interface.
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and auxiliary-loader accesses onto one data memory
// (IDLE/ISSUE/RDATA FSM). Define MEM_ARB_RR_EN for round-robin ties.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_reg, state_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              win_reg, win_next;
    logic              last_gnt;
    logic [1:0]        req_vec;
    logic [1:0]        pick_vec;
    logic [1:0]        gnt_vec;
    logic [1:0]        rvalid_vec;
    logic              issue_st;
    logic              rdata_st;

    assign req_vec[REQ_CPU] = cpu_req;
    assign req_vec[REQ_AUX] = aux_req;

    arb_pick u_pick (
        .req      (req_vec),
        .last_gnt (last_gnt),
        .gnt      (pick_vec)
    );

`ifdef MEM_ARB_RR_EN
    // Pointer moves only when a grant is actually issued, so an aborted access leaves it alone.
    logic last_gnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_reg <= REQ_AUX;
        end else if (state_reg == ISSUE) begin
            last_gnt_reg <= win_reg;
        end
    end

    assign last_gnt = last_gnt_reg;
`else
    assign last_gnt = REQ_AUX;
`endif

    always_comb begin
        state_next = state_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        win_next   = win_reg;
        case (state_reg)
            IDLE, RDATA: begin
                // Requests are sampled only here, so a req dropped during ISSUE is never seen.
                if (|req_vec) begin
                    state_next = ISSUE;
                    win_next   = onehot_to_id(pick_vec);
                    if (pick_vec[REQ_AUX]) begin
                        we_next    = aux_we;
                        addr_next  = aux_addr;
                        wdata_next = aux_wdata;
                    end else begin
                        we_next    = cpu_we;
                        addr_next  = cpu_addr;
                        wdata_next = cpu_wdata;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            ISSUE: begin
                state_next = we_reg ? IDLE : RDATA;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            win_reg   <= REQ_CPU;
        end else begin
            state_reg <= state_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            win_reg   <= win_next;
        end
    end

    // All outputs decode from registered state, so reset clears them immediately.
    assign issue_st = (state_reg == ISSUE);
    assign rdata_st = (state_reg == RDATA);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign gnt_vec[gi]    = issue_st && (win_reg == 1'(gi));
            assign rvalid_vec[gi] = rdata_st && (win_reg == 1'(gi));
        end
    endgenerate

    assign cpu_gnt    = gnt_vec[REQ_CPU];
    assign aux_gnt    = gnt_vec[REQ_AUX];
    assign cpu_rvalid = rvalid_vec[REQ_CPU];
    assign aux_rvalid = rvalid_vec[REQ_AUX];

    assign mem_wr_en = issue_st && we_reg;
    assign mem_addr  = issue_st ? addr_reg  : '0;
    assign mem_wdata = issue_st ? wdata_reg : '0;
    assign rdata     = rdata_st ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios push expected grant/read
// events; a negedge monitor pops and compares each one the DUT presents.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req, cpu_we, aux_req, aux_we;
    logic [AW-1:0] cpu_addr, aux_addr;
    logic [DW-1:0] cpu_wdata, aux_wdata;
    logic          cpu_gnt, cpu_rvalid, aux_gnt, aux_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [44:0] exp_q[$];
    logic [44:0] mon_exp;
    logic [44:0] mon_act;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .aux_req    (aux_req),
        .aux_we     (aux_we),
        .aux_addr   (aux_addr),
        .aux_wdata  (aux_wdata),
        .aux_gnt    (aux_gnt),
        .aux_rvalid (aux_rvalid),
        .rdata      (rdata),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory; a few words are preloaded with known contents.
    always @(posedge clk) begin
        if (cyc < 2) begin
            mem[10'h005] <= 16'h1234;
            mem[10'h010] <= 16'hC010;
            mem[10'h020] <= 16'hA020;
            mem[10'h040] <= 16'h0000;
            mem[10'h3FF] <= 16'h0000;
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end else begin
            $display("[TB] ok   %s: 0x%0h (cycle %0d)", nm, act, cyc);
        end
    endtask

    function automatic logic [44:0] pk(input logic g, input logic id, input logic we,
                                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                                       input int c);
        logic [15:0] c16;
        c16 = c[15:0];
        return {g, id, we, a, d, c16};
    endfunction

    task automatic push_gnt(input int c, input logic id, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back(pk(1'b1, id, we, a, d, c));
    endtask

    task automatic push_rv(input int c, input logic id, input logic [DW-1:0] d);
        exp_q.push_back(pk(1'b0, id, 1'b0, '0, d, c));
    endtask

    // Event layout: {is_gnt, id, we, addr, data, cycle}.
    always @(negedge clk) begin
        if (!rst) begin
            if (cpu_gnt || aux_gnt || cpu_rvalid || aux_rvalid) begin
                chk("one_hot", {62'd0, cpu_gnt & aux_gnt, cpu_rvalid & aux_rvalid}, 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {60'd0, cpu_gnt, aux_gnt, cpu_rvalid, aux_rvalid}, 64'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (cpu_gnt || aux_gnt)
                        mon_act = pk(1'b1, aux_gnt, mem_wr_en, mem_addr, mem_wdata, cyc);
                    else
                        mon_act = pk(1'b0, aux_rvalid, 1'b0, '0, rdata, cyc);
                    chk("event", 64'(mon_act), 64'(mon_exp));
                end
            end
            if (mem_wr_en) chk("wr_en_with_gnt", {63'd0, cpu_gnt | aux_gnt}, 64'd1);
        end
    end

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_aux(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        aux_req = r; aux_we = w; aux_addr = a; aux_wdata = d;
    endtask

    task automatic check_quiet(input string nm);
        chk(nm, {17'd0, cpu_gnt, aux_gnt, cpu_rvalid, aux_rvalid, mem_wr_en, mem_addr, mem_wdata, rdata}, 64'd0);
        chk({nm, "_state"}, 64'(dut.state_reg), 64'(IDLE));
    endtask

    initial begin
        int k;
        set_cpu(1'b0, 1'b0, '0, '0);
        set_aux(1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        go(3);
        @(negedge clk);
        check_quiet("reset_outputs");
        rst = 1'b0;
        go(2);

        // CPU read of 0x005: gnt one cycle after sampling, data one cycle later.
        k = cyc;
        set_cpu(1'b1, 1'b0, 10'h005, 16'h0000);
        push_gnt(k + 1, REQ_CPU, 1'b0, 10'h005, 16'h0000);
        push_rv(k + 2, REQ_CPU, 16'h1234);
        go(1); cpu_req = 1'b0;
        go(3);

        // Aux write of 0xBEEF to 0x3FF, then the FSM must be back in IDLE.
        k = cyc;
        set_aux(1'b1, 1'b1, 10'h3FF, 16'hBEEF);
        push_gnt(k + 1, REQ_AUX, 1'b1, 10'h3FF, 16'hBEEF);
        go(1); aux_req = 1'b0;
        go(1);
        @(negedge clk);
        chk("write_idle_state", 64'(dut.state_reg), 64'(IDLE));
        chk("write_landed", 64'(mem[10'h3FF]), 64'h BEEF);
        go(2);

        // Both requesters hold read requests for four accesses.
        k = cyc;
        set_cpu(1'b1, 1'b0, 10'h010, 16'h0000);
        set_aux(1'b1, 1'b0, 10'h020, 16'h0000);
`ifdef MEM_ARB_RR_EN
        push_gnt(k + 1, REQ_CPU, 1'b0, 10'h010, 16'h0000); push_rv(k + 2, REQ_CPU, 16'hC010);
        push_gnt(k + 3, REQ_AUX, 1'b0, 10'h020, 16'h0000); push_rv(k + 4, REQ_AUX, 16'hA020);
        push_gnt(k + 5, REQ_CPU, 1'b0, 10'h010, 16'h0000); push_rv(k + 6, REQ_CPU, 16'hC010);
        push_gnt(k + 7, REQ_AUX, 1'b0, 10'h020, 16'h0000); push_rv(k + 8, REQ_AUX, 16'hA020);
`else
        for (int i = 0; i < 4; i++) begin
            push_gnt(k + 1 + 2 * i, REQ_CPU, 1'b0, 10'h010, 16'h0000);
            push_rv(k + 2 + 2 * i, REQ_CPU, 16'hC010);
        end
`endif
        go(7);
        cpu_req = 1'b0; aux_req = 1'b0;
        go(3);

        // CPU read completes while aux waits: aux is issued right behind, no idle gap.
        k = cyc;
        set_cpu(1'b1, 1'b0, 10'h005, 16'h0000);
        push_gnt(k + 1, REQ_CPU, 1'b0, 10'h005, 16'h0000);
        push_rv(k + 2, REQ_CPU, 16'h1234);
        push_gnt(k + 3, REQ_AUX, 1'b0, 10'h020, 16'h0000);
        push_rv(k + 4, REQ_AUX, 16'hA020);
        go(1);
        cpu_req = 1'b0;
        set_aux(1'b1, 1'b0, 10'h020, 16'h0000);
        go(2);
        aux_req = 1'b0;
        go(3);

        // CPU asserts during aux ISSUE and withdraws before it could be sampled.
        k = cyc;
        set_aux(1'b1, 1'b0, 10'h020, 16'h0000);
        push_gnt(k + 1, REQ_AUX, 1'b0, 10'h020, 16'h0000);
        push_rv(k + 2, REQ_AUX, 16'hA020);
        go(1);
        aux_req = 1'b0;
        set_cpu(1'b1, 1'b0, 10'h007, 16'h0000);
        go(1);
        cpu_req = 1'b0;
        go(3);

        // Reset lands in the ISSUE cycle of an aux write: the write must be abandoned.
        k = cyc;
        set_aux(1'b1, 1'b1, 10'h040, 16'h5555);
        go(1);
        rst = 1'b1;
        aux_req = 1'b0;
        @(negedge clk);
        check_quiet("reset_in_issue");
        go(1);
        rst = 1'b0;
        go(4);
        @(negedge clk);
        chk("aborted_write_absent", 64'(mem[10'h040]), 64'h0000);
        chk("post_reset_state", 64'(dut.state_reg), 64'(IDLE));
        go(1);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
